// File: rtl/excl_cov_monitor.sv
// Functional-coverage and result-checking monitor for a d/e -> and/or/xor block,
// with saturating statistics and a four-phase readout handshake.
module excl_cov_monitor #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             d,
   input  logic             e,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             clr,
   input  logic             rd_req,
   input  logic [2:0]       rd_addr,
   output logic             rd_ack,
   output logic [CNT_W-1:0] rd_data,
   output logic [3:0]       combo_hit,
   output logic             all_hit,
   output logic             mismatch
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CAPT   = 2'd1;
   localparam logic [1:0] ACK    = 2'd2;
   localparam logic [1:0] WAITLO = 2'd3;

   logic [1:0]       state;
   logic [2:0]       addr_q;
   logic [CNT_W-1:0] rd_data_q;

   logic [3:0]       combo_q,    combo_n;
   logic             mis_q,      mis_n;
   logic             prev_valid, prev_valid_n;
   logic             prev_d,     prev_d_n;
   logic             prev_e,     prev_e_n;
   logic [CNT_W-1:0] tog_d_q,    tog_d_n;
   logic [CNT_W-1:0] tog_e_q,    tog_e_n;
   logic [CNT_W-1:0] mis_cnt_q,  mis_cnt_n;
   logic [CNT_W-1:0] smp_cnt_q,  smp_cnt_n;
   logic [CNT_W-1:0] rd_mux;
   logic             err;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Next-state statistics are computed here so the readout mux can capture
   // the values committed on the same edge as the CAPT->ACK transition.
   always_comb begin
      combo_n      = combo_q;
      mis_n        = mis_q;
      prev_valid_n = prev_valid;
      prev_d_n     = prev_d;
      prev_e_n     = prev_e;
      tog_d_n      = tog_d_q;
      tog_e_n      = tog_e_q;
      mis_cnt_n    = mis_cnt_q;
      smp_cnt_n    = smp_cnt_q;
      err          = (a != (d & e)) || (b != (d | e)) || (c != (d ^ e));
      if (clr) begin
         combo_n      = '0;
         mis_n        = 1'b0;
         prev_valid_n = 1'b0;
         prev_d_n     = 1'b0;
         prev_e_n     = 1'b0;
         tog_d_n      = '0;
         tog_e_n      = '0;
         mis_cnt_n    = '0;
         smp_cnt_n    = '0;
      end else if (en) begin
         combo_n[{d, e}] = 1'b1;
         if (err) begin
            mis_n     = 1'b1;
            mis_cnt_n = sat_inc(mis_cnt_q);
         end
         if (prev_valid && (d != prev_d)) tog_d_n = sat_inc(tog_d_q);
         if (prev_valid && (e != prev_e)) tog_e_n = sat_inc(tog_e_q);
         prev_valid_n = 1'b1;
         prev_d_n     = d;
         prev_e_n     = e;
         smp_cnt_n    = sat_inc(smp_cnt_q);
      end
   end

   always_comb begin
      rd_mux = '0;
      case (addr_q)
         3'd0:    rd_mux = CNT_W'(combo_n);
         3'd1:    rd_mux = tog_d_n;
         3'd2:    rd_mux = tog_e_n;
         3'd3:    rd_mux = mis_cnt_n;
         3'd4:    rd_mux = smp_cnt_n;
         3'd5:    rd_mux = CNT_W'({mis_n, &combo_n});
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         combo_q    <= '0;
         mis_q      <= 1'b0;
         prev_valid <= 1'b0;
         prev_d     <= 1'b0;
         prev_e     <= 1'b0;
         tog_d_q    <= '0;
         tog_e_q    <= '0;
         mis_cnt_q  <= '0;
         smp_cnt_q  <= '0;
      end else begin
         combo_q    <= combo_n;
         mis_q      <= mis_n;
         prev_valid <= prev_valid_n;
         prev_d     <= prev_d_n;
         prev_e     <= prev_e_n;
         tog_d_q    <= tog_d_n;
         tog_e_q    <= tog_e_n;
         mis_cnt_q  <= mis_cnt_n;
         smp_cnt_q  <= smp_cnt_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         rd_data_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_req) begin
                  addr_q <= rd_addr;
                  state  <= CAPT;
               end
            end
            CAPT: begin
               rd_data_q <= rd_mux;
               state     <= ACK;
            end
            ACK:     state <= WAITLO;
            default: if (!rd_req) state <= IDLE;
         endcase
      end
   end

   assign rd_ack    = (state == ACK);
   assign rd_data   = rd_data_q;
   assign combo_hit = combo_q;
   assign all_hit   = &combo_q;
   assign mismatch  = mis_q;

endmodule

// File: tb/tb_excl_cov_monitor.sv
// Directed bench for excl_cov_monitor: a default-width and a 4-bit instance
// driven in lockstep from a vector table plus hand-written handshake sequences.
module tb_excl_cov_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, d = 1'b0, e = 1'b0, a = 1'b0, b = 1'b0, c = 1'b0;
   logic       clr = 1'b0, rd_req = 1'b0;
   logic [2:0] rd_addr = '0;

   logic       rd_ack8, all8, mis8;
   logic [7:0] rd_data8;
   logic [3:0] combo8;
   logic       rd_ack4, all4, mis4;
   logic [3:0] rd_data4;
   logic [3:0] combo4;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   excl_cov_monitor dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .d(d), .e(e), .a(a), .b(b), .c(c),
      .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack8),
      .rd_data(rd_data8), .combo_hit(combo8), .all_hit(all8), .mismatch(mis8)
   );

   excl_cov_monitor #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .d(d), .e(e), .a(a), .b(b), .c(c),
      .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack4),
      .rd_data(rd_data4), .combo_hit(combo4), .all_hit(all4), .mismatch(mis4)
   );

   typedef struct {
      logic       en, clr, d, e, a, b, c;
      logic [3:0] x_combo;
      logic       x_mis, x_all;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic en_i, clr_i, d_i, e_i, a_i, b_i, c_i,
                      input logic [3:0] xc, input logic xm, xa);
      vec_t v;
      v.en = en_i; v.clr = clr_i; v.d = d_i; v.e = e_i; v.a = a_i; v.b = b_i; v.c = c_i;
      v.x_combo = xc; v.x_mis = xm; v.x_all = xa;
      vq.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         en = vq[i].en; clr = vq[i].clr; d = vq[i].d; e = vq[i].e;
         a = vq[i].a; b = vq[i].b; c = vq[i].c;
         step();
         check($sformatf("vec%0d combo8", i), 16'(combo8), 16'(vq[i].x_combo));
         check($sformatf("vec%0d combo4", i), 16'(combo4), 16'(vq[i].x_combo));
         check($sformatf("vec%0d mismatch", i), {14'd0, mis8, mis4}, {14'd0, vq[i].x_mis, vq[i].x_mis});
         check($sformatf("vec%0d all_hit", i), {14'd0, all8, all4}, {14'd0, vq[i].x_all, vq[i].x_all});
      end
      en = 1'b0; clr = 1'b0;
   endtask

   task automatic rd(input logic [2:0] addr, input logic [15:0] x8, input logic [15:0] x4);
      en = 1'b0; clr = 1'b0;
      rd_req = 1'b1; rd_addr = addr;
      step();
      check($sformatf("rd%0d ack in CAPT", addr), {14'd0, rd_ack8, rd_ack4}, 16'd0);
      step();
      check($sformatf("rd%0d ack in ACK", addr), {14'd0, rd_ack8, rd_ack4}, 16'd3);
      check($sformatf("rd%0d data8", addr), 16'(rd_data8), x8);
      check($sformatf("rd%0d data4", addr), 16'(rd_data4), x4);
      rd_req = 1'b0;
      step();
      check($sformatf("rd%0d ack in WAITLO", addr), {14'd0, rd_ack8, rd_ack4}, 16'd0);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ack, ack_cyc;
      logic [7:0] ack_data;

      // Scenario 1: 00,00,(en=0 11),01
      add(1,0, 0,0, 0,0,0, 4'b0001, 0, 0);  // 0
      add(1,0, 0,0, 0,0,0, 4'b0001, 0, 0);  // 1
      add(0,0, 1,1, 1,1,0, 4'b0001, 0, 0);  // 2 en=0 holds
      add(1,0, 0,1, 0,1,1, 4'b0011, 0, 0);  // 3
      // Scenario 4: clr collides with a de=11 sample, then one sample
      add(1,1, 1,1, 1,1,0, 4'b0000, 0, 0);  // 4
      add(1,0, 1,0, 0,1,1, 4'b0100, 0, 0);  // 5
      // Scenario 2: clr, then 00,01,11(a forced 0),10, then 00 with all three wrong
      add(0,1, 0,0, 0,0,0, 4'b0000, 0, 0);  // 6
      add(1,0, 0,0, 0,0,0, 4'b0001, 0, 0);  // 7
      add(1,0, 0,1, 0,1,1, 4'b0011, 0, 0);  // 8
      add(1,0, 1,1, 0,1,0, 4'b1011, 1, 0);  // 9
      add(1,0, 1,0, 0,1,1, 4'b1111, 1, 1);  // 10
      add(1,0, 0,0, 1,1,1, 4'b1111, 1, 1);  // 11

      #2;
      check("reset combo8", 16'(combo8), 16'd0);
      check("reset outs", {11'd0, rd_ack8, all8, mis8, rd_ack4, mis4}, 16'd0);
      check("reset data", {4'd0, rd_data8, rd_data4}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      apply(0, 4);
      rd(3'd0, 16'h3, 16'h3);
      rd(3'd2, 16'd1, 16'd1);
      rd(3'd4, 16'd3, 16'd3);
      rd(3'd1, 16'd0, 16'd0);
      rd(3'd5, 16'd0, 16'd0);
      rd(3'd6, 16'd0, 16'd0);

      apply(4, 5);
      rd(3'd4, 16'd0, 16'd0);
      rd(3'd0, 16'd0, 16'd0);
      apply(5, 6);
      rd(3'd4, 16'd1, 16'd1);
      rd(3'd1, 16'd0, 16'd0);

      apply(6, 12);
      rd(3'd5, 16'd3, 16'd3);
      rd(3'd3, 16'd2, 16'd2);
      rd(3'd1, 16'd2, 16'd2);
      rd(3'd2, 16'd2, 16'd2);
      rd(3'd4, 16'd5, 16'd5);
      rd(3'd0, 16'hF, 16'hF);
      rd(3'd7, 16'd0, 16'd0);

      // Scenario 3: saturation of the 4-bit instance
      clr = 1'b1; step(); clr = 1'b0;
      for (int i = 0; i < 40; i++) begin
         en = 1'b1; d = i[0]; e = 1'b0; a = 1'b0; b = i[0]; c = i[0];
         step();
      end
      en = 1'b0;
      check("sat combo", {8'd0, combo8, combo4}, 16'h0055);
      check("sat mismatch", {14'd0, mis8, mis4}, 16'd0);
      rd(3'd1, 16'd39, 16'd15);
      rd(3'd4, 16'd40, 16'd15);
      rd(3'd2, 16'd0, 16'd0);

      // Scenario 5: rd_req held high, rd_addr changes after the first cycle
      n_ack = 0; ack_cyc = 0; ack_data = '0;
      rd_req = 1'b1; rd_addr = 3'd4;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         step();
         if (cyc == 1) rd_addr = 3'd1;
         if (rd_ack8) begin
            n_ack++;
            ack_cyc = cyc;
            ack_data = rd_data8;
         end
      end
      check("hold ack count", 16'(n_ack), 16'd1);
      check("hold ack cycle", 16'(ack_cyc), 16'd2);
      check("hold ack data", 16'(ack_data), 16'd40);
      rd_req = 1'b0;
      step(); step();
      check("hold data after", 16'(rd_data8), 16'd40);

      // Scenario 6: reset while in CAPT
      rd_req = 1'b1; rd_addr = 3'd4;
      step();
      rst_n = 1'b0;
      #1;
      check("rst ack/flags", {11'd0, rd_ack8, all8, mis8, rd_ack4, mis4}, 16'd0);
      check("rst combo", {8'd0, combo8, combo4}, 16'd0);
      check("rst data", {4'd0, rd_data8, rd_data4}, 16'd0);
      rd_req = 1'b0;
      n_ack = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         step();
         if (rd_ack8 || rd_ack4) n_ack++;
      end
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         step();
         if (rd_ack8 || rd_ack4) n_ack++;
      end
      check("rst no ack", 16'(n_ack), 16'd0);
      en = 1'b1; d = 1'b1; e = 1'b1; a = 1'b1; b = 1'b1; c = 1'b0;
      step();
      en = 1'b0;
      check("post-rst combo", {8'd0, combo8, combo4}, 16'h0088);
      rd(3'd4, 16'd1, 16'd1);
      rd(3'd1, 16'd0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
